// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader / program-RAM write arbiter.
//   state_e    : loader FSM states
//   SYNC_BYTE  : byte that starts a load frame
//   RAM_AW     : program-RAM word-address width
//   DATA_W     : program-RAM word width
package prog_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR_H  = 4'd1,
    ST_ADDR_L  = 4'd2,
    ST_CNT_H   = 4'd3,
    ST_CNT_L   = 4'd4,
    ST_DATA_H  = 4'd5,
    ST_DATA_L  = 4'd6,
    ST_CSUM    = 4'd7,
    ST_RELEASE = 4'd8
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         RAM_AW    = 12;
  localparam int         DATA_W    = 16;

endpackage

// File: rtl/prog_loader_arb.sv
// Program loader and program-RAM write arbiter.
//
// While idle, the CPU owns the program-RAM write port (combinational
// pass-through). With load_en high, UART bytes are consumed; a sync byte
// starts a frame:
//   A5, addr_h, addr_l, cnt_h, cnt_l, {data_h, data_l} x cnt, checksum
// The CPU is held in reset for the duration of the frame, and the frame
// ends with a one-cycle done (checksum matched) or err (mismatch) pulse.
//
// Ports:
//   clk, resetq              clock, synchronous active-low reset
//   load_en                  loader may consume UART bytes (sampled in IDLE)
//   rx_valid, rx_data        UART RX byte available / byte
//   rx_rd                    one-cycle pop strobe to the UART RX
//   cpu_mem_wr/addr, cpu_dout  CPU program-RAM write request
//   ram_we/waddr/wdata       program-RAM write port
//   cpu_resetq               registered active-low CPU reset
//   busy, done, err          status
//
// Byte handshake: a byte is taken in the cycle where rx_valid=1, the
// current state consumes bytes and rx_rd was low in the previous cycle;
// rx_rd is high in exactly that cycle and rx_data is captured at its
// closing edge. rx_rd is therefore never high on two consecutive cycles.
module prog_loader_arb
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              resetq,
  input  logic              load_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_rd,
  input  logic              cpu_mem_wr,
  input  logic [15:0]       cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_resetq,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e              state_q, state_d;
  logic                rx_rd_prev_q;
  logic [RAM_AW-1:0]   addr_q, addr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [7:0]          sum_q, sum_d;
  logic [7:0]          data_hi_q, data_hi_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [7:0]          csum_q, csum_d;
  logic                cpu_resetq_q, cpu_resetq_d;

  logic                consume;
  logic                accept;
  logic                in_idle;

  // Only the word-select bits of the CPU byte address reach the RAM.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^{cpu_mem_addr[15:13], cpu_mem_addr[0]};

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    data_hi_d    = data_hi_q;
    wdata_d      = wdata_q;
    wr_d         = 1'b0;
    csum_d       = csum_q;

    in_idle = (state_q == ST_IDLE);
    // load_en only matters in IDLE; once a frame has started it runs to
    // completion regardless.
    consume = in_idle ? load_en : (state_q != ST_RELEASE);
    accept  = rx_valid && consume && !rx_rd_prev_q;

    // The write cycle follows the DATA_L accept; bump address/count here
    // so the RAM sees the pre-increment address.
    if (wr_q) begin
      addr_d = addr_q + 1'b1;
      cnt_d  = cnt_q - 1'b1;
    end

    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = ST_ADDR_H;
            sum_d   = 8'h00;
          end
        end
        ST_ADDR_H: begin
          addr_d[11:8] = rx_data[3:0];
          state_d      = ST_ADDR_L;
        end
        ST_ADDR_L: begin
          addr_d[7:0] = rx_data;
          state_d     = ST_CNT_H;
        end
        ST_CNT_H: begin
          cnt_d[15:8] = rx_data;
          state_d     = ST_CNT_L;
        end
        ST_CNT_L: begin
          cnt_d[7:0] = rx_data;
          state_d    = ({cnt_q[15:8], rx_data} == 16'h0000) ? ST_CSUM : ST_DATA_H;
        end
        ST_DATA_H: begin
          data_hi_d = rx_data;
          sum_d     = sum_q + rx_data;
          state_d   = ST_DATA_L;
        end
        ST_DATA_L: begin
          wdata_d = {data_hi_q, rx_data};
          sum_d   = sum_q + rx_data;
          wr_d    = 1'b1;
          // cnt_q still holds the pre-write count; it drops to 0 on the
          // write cycle when this was the last word.
          state_d = (cnt_q == 16'h0001) ? ST_CSUM : ST_DATA_H;
        end
        ST_CSUM: begin
          csum_d  = rx_data;
          state_d = ST_RELEASE;
        end
        default: ;
      endcase
    end

    if (state_q == ST_RELEASE) begin
      state_d = ST_IDLE;
    end

    cpu_resetq_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_q      <= ST_IDLE;
      rx_rd_prev_q <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      sum_q        <= '0;
      data_hi_q    <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      csum_q       <= '0;
      cpu_resetq_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_rd_prev_q <= accept;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      data_hi_q    <= data_hi_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      csum_q       <= csum_d;
      cpu_resetq_q <= cpu_resetq_d;
    end
  end

  always_comb begin
    rx_rd      = accept;
    busy       = !in_idle;
    cpu_resetq = cpu_resetq_q;
    done       = (state_q == ST_RELEASE) && (csum_q == sum_q);
    err        = (state_q == ST_RELEASE) && (csum_q != sum_q);
    if (in_idle) begin
      ram_we    = cpu_mem_wr;
      ram_waddr = cpu_mem_addr[12:1];
      ram_wdata = cpu_dout;
    end else begin
      ram_we    = wr_q;
      ram_waddr = addr_q;
      ram_wdata = wdata_q;
    end
  end

endmodule

// File: doc/prog_loader_arb.md
PROG_LOADER_ARB -- requirements
Module: prog_loader_arb

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk (rising edge) and resetq (synchronous, active-low).
REQ-002 Ports: clk  in  1  system clock.
REQ-003 Ports: resetq  in  1  synchronous active-low reset.
REQ-004 Ports: load_en  in  1  loader may consume UART bytes while high.
REQ-005 Ports: rx_valid  in  1  UART RX byte available.
REQ-006 Ports: rx_data  in  8  UART RX byte.
REQ-007 Ports: rx_rd  out  1  one-cycle pop strobe to UART RX.
REQ-008 Ports: cpu_mem_wr  in  1  CPU program-RAM write request.
REQ-009 Ports: cpu_mem_addr  in  16  CPU byte address; bits [12:1] select the word.
REQ-010 Ports: cpu_dout  in  16  CPU write data.
REQ-011 Ports: ram_we  out  1  program-RAM write enable.
REQ-012 Ports: ram_waddr  out  12  program-RAM word address.
REQ-013 Ports: ram_wdata  out  16  program-RAM write data.
REQ-014 Ports: cpu_resetq  out  1  active-low reset to CPU; low while loading.
REQ-015 Ports: busy  out  1  high in any state other than IDLE.
REQ-016 Ports: done  out  1  one-cycle pulse: load finished, checksum matched.
REQ-017 Ports: err  out  1  one-cycle pulse: load finished, checksum mismatched.

Function
REQ-018 FSM states SHALL be IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, CSUM, RELEASE.
REQ-019 Byte accept rule: rx_rd=1 for exactly one cycle when rx_valid=1, state consumes bytes, and rx_rd was 0 in the previous cycle; rx_data is captured in that same cycle. rx_rd SHALL never be asserted on consecutive cycles.
REQ-020 IDLE with load_en=0: rx_rd=0 always, so the UART is left to the CPU.
REQ-021 IDLE with load_en=1: every byte is consumed. 0xA5 moves to ADDR_H; any other byte is discarded and the FSM stays in IDLE.
REQ-022 ADDR_H/ADDR_L capture the big-endian start word address; only bits [11:0] are kept.
REQ-023 CNT_H/CNT_L capture the big-endian 16-bit word count. Count 0 goes from CNT_L directly to CSUM; otherwise to DATA_H.
REQ-024 DATA_H/DATA_L capture each word high byte then low byte.
REQ-025 The cycle after the DATA_L byte is accepted: ram_we=1 for one cycle, ram_waddr = current address, ram_wdata = the assembled word.
REQ-026 After each loader write: address increments modulo 4096 (0xFFF wraps to 0x000) and count decrements. Count reaching 0 goes to CSUM; otherwise to DATA_H.
REQ-027 Checksum SHALL be the 8-bit modulo-256 sum of all data bytes only, cleared on entry to ADDR_H.
REQ-028 CSUM accepts one byte and goes to RELEASE. RELEASE lasts one cycle, pulses done (byte equals sum) or err (mismatch), then returns to IDLE.
REQ-029 Arbitration in IDLE: ram_we=cpu_mem_wr, ram_waddr=cpu_mem_addr[12:1], ram_wdata=cpu_dout, combinational pass-through with zero latency.
REQ-030 Outside IDLE: CPU write inputs are ignored, and ram_we is driven only by the loader.
REQ-031 cpu_resetq SHALL be registered, low from the cycle after the sync byte is accepted through the RELEASE cycle, and high again the cycle after RELEASE.
REQ-032 A CPU write in the same cycle the sync byte is accepted SHALL still pass through.
REQ-033 load_en deasserting mid-load SHALL NOT abort the load; it is sampled only in IDLE.
REQ-034 busy=1 in every state except IDLE.

Reset
REQ-035 While resetq=0 at a clock edge, the following SHALL be set next cycle: state=IDLE, rx_rd=0, loader ram_we=0, done=0, err=0, busy=0, cpu_resetq=0, address/count/checksum registers=0.
REQ-036 cpu_resetq SHALL go high the first cycle after resetq returns high, unless a load has started.
REQ-037 Reset mid-load SHALL abandon the load with no further RAM writes and no done/err pulse.

Structure
REQ-038 Package prog_loader_pkg SHALL hold: the state enum, SYNC_BYTE=8'hA5, RAM_AW=12, DATA_W=16.
REQ-039 The block SHALL be a single module with no sub-modules; the checksum accumulator and address counter are inline.

Verification
REQ-040 load_en=1; bytes A5 00 10 00 02 12 34 56 78, then checksum 14 -> writes 0x1234@0x010 and 0x5678@0x011; done pulses once; cpu_resetq low throughout.
REQ-041 Same stream with checksum 15 -> both words written; err pulses; done stays 0.
REQ-042 Start address 0x0FFF, count 2, data AAAA BBBB -> writes to 0xFFF then 0x000.
REQ-043 Bytes 00 A5 00 00 00 00 00 -> leading 00 discarded; count 0; done pulses; no loader writes.
REQ-044 load_en=0 with rx_valid held 1 -> rx_rd never asserts; cpu_mem_wr=1 at addr 0x0020 with data 0xBEEF -> ram_we=1, waddr=0x010, wdata=0xBEEF in the same cycle.
REQ-045 resetq=0 for one cycle after the DATA_H byte -> FSM returns to IDLE; no write; no done/err; cpu_resetq high after reset.
